// File: rtl/up_plc_pkg.sv
// Shared constants for the up_plc micro-sequencer: opcodes, instruction layout,
// I/O bit indices and the fixed PLC program image.
package up_plc_pkg;

  localparam int OP_W   = 4;
  localparam int ARG_W  = 12;
  localparam int INSN_W = OP_W + ARG_W;
  localparam int PC_W   = 4;
  localparam int DATA_W = 16;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LD   = 4'h1;
  localparam logic [OP_W-1:0] OP_LDN  = 4'h2;
  localparam logic [OP_W-1:0] OP_AND  = 4'h3;
  localparam logic [OP_W-1:0] OP_ANDN = 4'h4;
  localparam logic [OP_W-1:0] OP_OR   = 4'h5;
  localparam logic [OP_W-1:0] OP_ORN  = 4'h6;
  localparam logic [OP_W-1:0] OP_ST   = 4'h7;
  localparam logic [OP_W-1:0] OP_LDA  = 4'h8;
  localparam logic [OP_W-1:0] OP_GEI  = 4'h9;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hA;

  localparam logic [1:0] IO_START = 2'd0;
  localparam logic [1:0] IO_STOP  = 2'd1;
  localparam logic [1:0] IO_MOTOR = 2'd2;
  localparam logic [1:0] IO_MAX   = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ARG_W-1:0] arg;
  } instr_t;

  function automatic instr_t mk(input logic [OP_W-1:0] op, input logic [ARG_W-1:0] arg);
    instr_t i;
    i.op  = op;
    i.arg = arg;
    return i;
  endfunction

  // Motor start/stop latch with over-pressure trip; trip threshold is {hi, 4'h0}.
  function automatic instr_t rom_word(input logic [PC_W-1:0] a, input logic [ARG_W-1:0] hi);
    instr_t i;
    case (a)
      4'd0:    i = mk(OP_LDA,  12'd0);
      4'd1:    i = mk(OP_GEI,  hi);
      4'd2:    i = mk(OP_ST,   {10'd0, IO_MAX});
      4'd3:    i = mk(OP_LD,   {10'd0, IO_START});
      4'd4:    i = mk(OP_OR,   {10'd0, IO_MOTOR});
      4'd5:    i = mk(OP_ANDN, {10'd0, IO_STOP});
      4'd6:    i = mk(OP_ANDN, {10'd0, IO_MAX});
      4'd7:    i = mk(OP_ST,   {10'd0, IO_MOTOR});
      4'd8:    i = mk(OP_JMP,  12'd0);
      default: i = mk(OP_NOP,  12'd0);
    endcase
    return i;
  endfunction

endpackage

// File: rtl/up_plc_if.sv
// Instruction fetch bus between the sequencer (master) and program ROM (slave).
interface up_plc_if;
  import up_plc_pkg::*;

  logic [PC_W-1:0] addr;
  instr_t          instr;

  modport master (output addr, input  instr);
  modport slave  (input  addr, output instr);
endinterface

// File: rtl/up_plc_rom.sv
// 16x16 combinational program ROM; GEI operand comes from the threshold parameter.
module up_plc_rom
  import up_plc_pkg::*;
#(
  parameter logic [ARG_W-1:0] PRESSURE_MAX_HI = 12'hC00
) (
  up_plc_if.slave rom
);

  assign rom.instr = rom_word(rom.addr, PRESSURE_MAX_HI);

endmodule

// File: rtl/up_plc.sv
// Bit-oriented PLC micro-sequencer: one instruction per clock from ROM, driving
// motor/max pins from output latches and sampling pressure/start/stop pins each edge.
module up_plc
  import up_plc_pkg::*;
#(
  parameter logic [ARG_W-1:0] PRESSURE_MAX_HI = 12'hC00
) (
  input  logic              clk_in,
  input  logic              rst_in,
  inout  wire  [DATA_W-1:0] a0_io,
  inout  wire               d0_io,
  inout  wire               d1_io,
  inout  wire               d2_io,
  inout  wire               d3_io
);

  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_ia;
  logic              r_rlo;
  logic              r_d2;
  logic              r_d3;
  logic              r_id0;
  logic              r_id1;

  logic [OP_W-1:0]   w_op;
  logic [ARG_W-1:0]  w_arg;
  logic              w_bit;

  up_plc_if u_fetch ();

  up_plc_rom #(.PRESSURE_MAX_HI(PRESSURE_MAX_HI)) u_rom (.rom(u_fetch.slave));

  assign u_fetch.addr = r_pc;
  assign w_op         = u_fetch.instr.op;
  assign w_arg        = u_fetch.instr.arg;

  // D[0..1] are the sampled input pins, D[2..3] read back the output latches.
  always_comb begin
    w_bit = 1'b0;
    case (w_arg[1:0])
      IO_START: w_bit = r_id0;
      IO_STOP:  w_bit = r_id1;
      IO_MOTOR: w_bit = r_d2;
      IO_MAX:   w_bit = r_d3;
      default:  w_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pc  <= '0;
      r_acc <= '0;
      r_ia  <= '0;
      r_rlo <= 1'b0;
      r_d2  <= 1'b0;
      r_d3  <= 1'b0;
      r_id0 <= 1'b0;
      r_id1 <= 1'b0;
    end else begin
      r_ia  <= a0_io;
      r_id0 <= d0_io;
      r_id1 <= d1_io;
      r_pc  <= r_pc + 1'b1;
      case (w_op)
        OP_LD:   r_rlo <= w_bit;
        OP_LDN:  r_rlo <= ~w_bit;
        OP_AND:  r_rlo <= r_rlo & w_bit;
        OP_ANDN: r_rlo <= r_rlo & ~w_bit;
        OP_OR:   r_rlo <= r_rlo | w_bit;
        OP_ORN:  r_rlo <= r_rlo | ~w_bit;
        OP_ST: begin
          if (w_arg[1:0] == IO_MOTOR) r_d2 <= r_rlo;
          if (w_arg[1:0] == IO_MAX)   r_d3 <= r_rlo;
        end
        OP_LDA:  r_acc <= r_ia;
        OP_GEI:  r_rlo <= (r_acc >= {w_arg, 4'h0});
        OP_JMP:  r_pc  <= w_arg[PC_W-1:0];
        default: ;
      endcase
    end
  end

  // Only the two output pins are driven; the input pins stay high-Z from this side.
  assign d2_io = r_d2;
  assign d3_io = r_d3;

endmodule

// File: tb/tb_up_plc.sv
// Self-checking bench for up_plc: scan-level behavioural model compared every cycle,
// directed scenarios for start/stop/trip/reset and a randomized input soak.
module tb_up_plc;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [15:0] r_press;
  logic        r_start;
  logic        r_stop;

  wire  [15:0] a0_io;
  wire         d0_io;
  wire         d1_io;
  wire         d2_io;
  wire         d3_io;

  assign a0_io = r_press;
  assign d0_io = r_start;
  assign d1_io = r_stop;

  always #5 clk_in = ~clk_in;

  up_plc #(.PRESSURE_MAX_HI(12'hC00)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .a0_io (a0_io),
    .d0_io (d0_io),
    .d1_io (d1_io),
    .d2_io (d2_io),
    .d3_io (d3_io)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: the scan repeats every 9 edges; each output is derived from the pin
  // values sampled one edge before the scan step that consumes them.
  int          m_edge;
  logic [15:0] m_ia, m_acc;
  logic        m_id0, m_id1, m_start_s, m_stop_s, m_d2, m_d3;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edge = 0; m_ia = '0; m_acc = '0;
    m_id0 = 0; m_id1 = 0; m_start_s = 0; m_stop_s = 0; m_d2 = 0; m_d3 = 0;
  endtask

  task automatic model_edge();
    case (m_edge % 9)
      0: m_acc     = m_ia;
      2: m_d3      = (m_acc >= 16'hC000);
      3: m_start_s = m_id0;
      5: m_stop_s  = m_id1;
      7: m_d2      = (m_start_s | m_d2) & ~m_stop_s & ~m_d3;
      default: ;
    endcase
    m_ia  = r_press;
    m_id0 = r_start;
    m_id1 = r_stop;
    m_edge++;
  endtask

  task automatic tick(input string tag);
    @(posedge clk_in);
    if (rst_in) model_edge();
    #1;
    chk({tag, "_d2"}, {15'd0, d2_io}, {15'd0, m_d2});
    chk({tag, "_d3"}, {15'd0, d3_io}, {15'd0, m_d3});
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) tick(tag);
  endtask

  int lat;

  initial begin
    r_press = 16'hBFFF; r_start = 1'b1; r_stop = 1'b0; rst_in = 1'b0;
    model_reset();
    #2;
    chk("rst_d2_t0", {15'd0, d2_io}, 16'd0);
    chk("rst_d3_t0", {15'd0, d3_io}, 16'd0);
    run(5, "in_rst");

    // Release and latch the motor with a 20-cycle start pulse.
    rst_in = 1'b1;
    lat = 0;
    while (d2_io !== 1'b1 && lat < 20) begin tick("start"); lat++; end
    chk("start_latency_le15", {15'd0, (lat <= 15)}, 16'd1);
    run(20 - lat, "start");
    r_start = 1'b0;
    run(30, "hold");
    chk("run_d2", {15'd0, d2_io}, 16'd1);
    chk("run_d3", {15'd0, d3_io}, 16'd0);

    r_stop = 1'b1;
    lat = 0;
    while (d2_io !== 1'b0 && lat < 20) begin tick("stop"); lat++; end
    chk("stop_latency_le15", {15'd0, (lat <= 15)}, 16'd1);
    run(5, "stop");
    r_stop = 1'b0;
    run(20, "stopped");
    chk("stopped_d2", {15'd0, d2_io}, 16'd0);

    // Over-pressure trip at exactly the threshold, then recovery just below it.
    r_start = 1'b1; run(20, "start2"); r_start = 1'b0; run(10, "run2");
    chk("run2_d2", {15'd0, d2_io}, 16'd1);
    r_press = 16'hC000; run(20, "trip");
    chk("trip_d3", {15'd0, d3_io}, 16'd1);
    chk("trip_d2", {15'd0, d2_io}, 16'd0);
    r_press = 16'hBFFF; r_start = 1'b1; run(20, "recover"); r_start = 1'b0; run(10, "recover");
    chk("recover_d3", {15'd0, d3_io}, 16'd0);
    chk("recover_d2", {15'd0, d2_io}, 16'd1);

    r_stop = 1'b1; run(15, "clear"); r_stop = 1'b0; run(5, "clear");
    r_start = 1'b1; r_stop = 1'b1; run(25, "both");
    chk("both_d2", {15'd0, d2_io}, 16'd0);
    r_start = 1'b0; r_stop = 1'b0; run(10, "both_rel");
    chk("both_rel_d2", {15'd0, d2_io}, 16'd0);

    // Asynchronous reset while the program counter sits at address 5.
    r_start = 1'b1; run(20, "start3"); r_start = 1'b0; run(5, "run3");
    lat = 0;
    while (m_edge % 9 != 5 && lat < 20) begin tick("seek_pc5"); lat++; end
    chk("pc5_d2", {15'd0, d2_io}, 16'd1);
    #2;
    rst_in = 1'b0;
    #1;
    chk("async_rst_d2", {15'd0, d2_io}, 16'd0);
    chk("async_rst_d3", {15'd0, d3_io}, 16'd0);
    model_reset();
    r_press = 16'hC000;
    run(3, "in_rst2");
    rst_in = 1'b1;
    run(11, "restart");
    chk("restart_d3_e11", {15'd0, d3_io}, 16'd0);
    tick("restart");
    chk("restart_d3_e12", {15'd0, d3_io}, 16'd1);

    // Randomized soak with occasional resets.
    r_press = 16'hBFFF; r_start = 1'b0; r_stop = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0)  r_start = ~r_start;
      if ($urandom_range(0, 14) == 0) r_stop  = ~r_stop;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 2))
          0:       r_press = 16'hBFFF;
          1:       r_press = 16'hC000;
          default: r_press = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 199) == 0) begin
        #3;
        rst_in = 1'b0;
        #1;
        chk("rand_async_rst_d2", {15'd0, d2_io}, 16'd0);
        model_reset();
        run(2, "rand_rst");
        rst_in = 1'b1;
      end
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
